// File: rtl/pts_tx_pkg.sv
// Shared types and parameter-legality helpers for the parallel-to-serial transmit sequencer.

package pts_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } tx_ctrl_state_t;

   localparam int unsigned MIN_NUM_BITS     = 2;
   localparam int unsigned MIN_CLKS_PER_BIT = 2;

   function automatic bit params_legal(input int unsigned num_bits,
                                       input int unsigned clks_per_bit);
      return (num_bits >= MIN_NUM_BITS) && (clks_per_bit >= MIN_CLKS_PER_BIT);
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Free-running modulo counter: counts 0..rollover_val-1 while enabled, with a registered
// flag that is high for the whole cycle in which the count sits at its final value.

module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;
   logic [NUM_CNT_BITS-1:0] last_val;
   logic                    flag_q, flag_d;

   assign last_val = rollover_val - NUM_CNT_BITS'(1);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = (count_q == last_val) ? '0 : count_q + NUM_CNT_BITS'(1);
      end
      // Flag tracks the next count so it lines up with count_out, not one cycle late.
      flag_d = !clear && (count_d == last_val);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         flag_q  <= flag_d;
      end
   end

   assign count_out     = count_q;
   assign rollover_flag = flag_q;

endmodule

// File: rtl/pts_tx_controller.sv
// Load/shift sequencer for the MSB-first parallel-to-serial shift register: one frame per
// handshake, each bit held for CLKS_PER_BIT clocks, tx_done pulsed on return to IDLE.

module pts_tx_controller
   import pts_tx_pkg::*;
#(
   parameter int unsigned NUM_BITS     = 9,
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                tx_valid,
   input  logic [NUM_BITS-1:0] tx_data,
   output logic                tx_ready,
   output logic [NUM_BITS-1:0] pts_data,
   output logic                load_enable,
   output logic                shift_enable,
   output logic                busy,
   output logic                tx_done
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
   localparam int unsigned BW = $clog2(NUM_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);
   localparam logic [TW-1:0] PERIOD   = TW'(CLKS_PER_BIT);

   if (!params_legal(NUM_BITS, CLKS_PER_BIT)) begin : gen_bad_params
      $error("pts_tx_controller: NUM_BITS and CLKS_PER_BIT must both be at least 2");
   end

   tx_ctrl_state_t      state_q, state_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [NUM_BITS-1:0] pts_data_q, pts_data_d;
   logic                tx_done_q, tx_done_d;
   logic [TW-1:0]       bit_timer;
   logic                period_end;

   flex_counter #(
      .NUM_CNT_BITS (TW)
   ) u_bit_timer (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (state_q == LOAD),
      .count_enable  (state_q == SHIFT),
      .rollover_val  (PERIOD),
      .count_out     (bit_timer),
      .rollover_flag (period_end)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      pts_data_d = pts_data_q;
      tx_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               pts_data_d = tx_data;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            // The final bit period ends without a shift; the register is simply abandoned.
            if (period_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  state_d   = IDLE;
                  tx_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         pts_data_q <= '0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         pts_data_q <= pts_data_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign tx_ready     = (state_q == IDLE);
   assign load_enable  = (state_q == LOAD);
   assign shift_enable = (state_q == SHIFT) && period_end && (bit_cnt_q != LAST_BIT);
   assign busy         = (state_q != IDLE);
   assign tx_done      = tx_done_q;
   assign pts_data     = pts_data_q;

   a_strobes_exclusive : assert property (@(posedge clk) disable iff (!n_rst)
      !(load_enable && shift_enable));

   a_period_end_at_last_count : assert property (@(posedge clk) disable iff (!n_rst)
      (state_q == SHIFT && period_end) |-> (bit_timer == PERIOD - TW'(1)));

endmodule

// File: tb/tb_pts_tx_controller.sv
// Bench for pts_tx_controller: a default (9-bit, 10 clk/bit) and a small (4-bit, 2 clk/bit)
// instance, each compared every cycle against a frame-timing model, plus pinned literal checks.

module tb_pts_tx_controller;

   logic clk;
   logic n_rst;
   logic v0, v1;
   logic [8:0] d0;
   logic [3:0] d1;
   logic rdy0, ld0, sh0, bsy0, dn0;
   logic rdy1, ld1, sh1, bsy1, dn1;
   logic [8:0] pts0;
   logic [3:0] pts1;

   pts_tx_controller #(.NUM_BITS(9), .CLKS_PER_BIT(10)) u_dut0 (
      .clk(clk), .n_rst(n_rst), .tx_valid(v0), .tx_data(d0), .tx_ready(rdy0),
      .pts_data(pts0), .load_enable(ld0), .shift_enable(sh0), .busy(bsy0), .tx_done(dn0)
   );

   pts_tx_controller #(.NUM_BITS(4), .CLKS_PER_BIT(2)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .tx_valid(v1), .tx_data(d1), .tx_ready(rdy1),
      .pts_data(pts1), .load_enable(ld1), .shift_enable(sh1), .busy(bsy1), .tx_done(dn1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit model_on = 1'b0;

   int nb [2] = '{9, 4};
   int cb [2] = '{10, 2};
   bit act_m [2] = '{1'b0, 1'b0};
   int acc_m [2] = '{0, 0};
   int pts_m [2] = '{0, 0};
   bit done_m [2] = '{1'b0, 1'b0};
   int sr [2] = '{0, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Model: a frame accepted in cycle a occupies cycles a+1 .. a+1+N*C; tx_done at a+2+N*C.
   always @(posedge clk) begin
      bit vin;
      int din;
      bit prev_ready;
      cyc++;
      if (!n_rst) model_on = 1'b1;
      for (int id = 0; id < 2; id++) begin
         vin        = (id == 0) ? v0 : v1;
         din        = (id == 0) ? int'(d0) : int'(d1);
         prev_ready = !act_m[id];
         done_m[id] = 1'b0;
         if (!n_rst) begin
            act_m[id] = 1'b0;
            pts_m[id] = 0;
         end else begin
            if (act_m[id] && (cyc - acc_m[id] == 2 + nb[id] * cb[id])) begin
               act_m[id]  = 1'b0;
               done_m[id] = 1'b1;
            end
            if (prev_ready && vin) begin
               act_m[id] = 1'b1;
               acc_m[id] = cyc - 1;
               pts_m[id] = din;
            end
         end
      end
   end

   task automatic compare(input int id, input logic rdy, input logic ld, input logic sh,
                          input logic bs, input logic dn, input logic [8:0] pts);
      int r, n, c, k;
      bit e_sh;
      string p;
      p = $sformatf("dut%0d ", id);
      n = nb[id];
      c = cb[id];
      r = cyc - acc_m[id];
      e_sh = act_m[id] && (r >= 2) && ((r - 1) % c == 0) && ((r - 1) / c <= n - 1);
      chk({p, "tx_ready"}, rdy, !act_m[id]);
      chk({p, "load_enable"}, ld, act_m[id] && (r == 1));
      chk({p, "shift_enable"}, sh, e_sh);
      chk({p, "busy"}, bs, act_m[id]);
      chk({p, "tx_done"}, dn, done_m[id]);
      chk({p, "pts_data"}, pts, pts_m[id]);
      if (act_m[id] && r >= 2) begin
         k = (r - 2) / c;
         chk({p, "serial"}, (sr[id] >> (n - 1)) & 1, (pts_m[id] >> (n - 1 - k)) & 1);
      end
      // Downstream shift register, driven by the DUT strobes; content valid next cycle.
      if (ld) sr[id] = int'(pts);
      else if (sh) sr[id] = (sr[id] << 1) & ((1 << n) - 1);
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         compare(0, rdy0, ld0, sh0, bsy0, dn0, pts0);
         compare(1, rdy1, ld1, sh1, bsy1, dn1, {5'b0, pts1});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nsh0, first_sh0, last_sh0, load_cyc0, done_cyc0, done_cyc1, cnt;
      int loads[$];
      int dones[$];
      int sh1_q[$];
      logic [8:0] stream0;
      logic [3:0] stream1;
      logic [8:0] pts_mid;

      n_rst = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      d0 = '0;
      d1 = '0;
      repeat (3) step();
      chk("reset tx_ready", rdy0, 1'b1);
      chk("reset busy", bsy0, 1'b0);
      chk("reset pts_data", pts0, 9'h000);
      n_rst = 1'b1;

      // Idle window
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         d0 = 9'($urandom);
         d1 = 4'($urandom);
         if (ld0 || sh0 || bsy0 || dn0 || ld1 || sh1 || bsy1 || dn1) cnt++;
         step();
      end
      chk("idle strobes", cnt, 0);
      chk("idle pts_data", pts0, 9'h000);

      // Directed frame on both instances
      d0 = 9'h1A5;
      v0 = 1'b1;
      d1 = 4'b1001;
      v1 = 1'b1;
      step();
      v0 = 1'b0;
      v1 = 1'b0;
      d0 = 9'h000;
      d1 = 4'h0;
      nsh0 = 0; first_sh0 = -1; last_sh0 = -1; load_cyc0 = -1; done_cyc0 = -1; done_cyc1 = -1;
      stream0 = '0;
      stream1 = '0;
      for (int r = 1; r <= 100; r++) begin
         if (ld0) load_cyc0 = r;
         if (sh0) begin
            nsh0++;
            if (first_sh0 < 0) first_sh0 = r;
            last_sh0 = r;
         end
         if (dn0) done_cyc0 = r;
         if (r >= 2 && (r - 2) % 10 == 0 && r < 92) stream0 = {stream0[7:0], sr[0][8]};
         if (sh1) sh1_q.push_back(r);
         if (dn1) done_cyc1 = r;
         if (r >= 2 && (r - 2) % 2 == 0 && r < 10) stream1 = {stream1[2:0], sr[1][3]};
         step();
      end
      chk("frame0 load cycle", load_cyc0, 1);
      chk("frame0 shift count", nsh0, 8);
      chk("frame0 first shift", first_sh0, 11);
      chk("frame0 last shift", last_sh0, 81);
      chk("frame0 done cycle", done_cyc0, 92);
      chk("frame0 serial stream", stream0, 9'h1A5);
      chk("small shift count", sh1_q.size(), 3);
      if (sh1_q.size() == 3) begin
         chk("small shift 0", sh1_q[0], 3);
         chk("small shift 1", sh1_q[1], 5);
         chk("small shift 2", sh1_q[2], 7);
      end
      chk("small done cycle", done_cyc1, 10);
      chk("small serial stream", stream1, 4'b1001);

      // Back-to-back frames with tx_valid held high across the done cycle
      d0 = 9'h0FF;
      v0 = 1'b1;
      step();
      d0 = 9'h100;
      pts_mid = '0;
      for (int r = 1; r <= 190; r++) begin
         if (ld0) loads.push_back(r);
         if (dn0) dones.push_back(r);
         if (r == 94) begin
            v0 = 1'b0;
            pts_mid = pts0;
         end
         step();
      end
      chk("b2b load count", loads.size(), 2);
      chk("b2b done count", dones.size(), 2);
      if (loads.size() == 2 && dones.size() == 2) begin
         chk("b2b second load", loads[1], 93);
         chk("b2b first done", dones[0], 92);
         chk("b2b second done", dones[1], 184);
      end
      chk("b2b second data", pts_mid, 9'h100);

      // tx_valid held with tx_data toggling during the frame
      d0 = 9'h155;
      v0 = 1'b1;
      step();
      cnt = 0;
      nsh0 = 0;
      pts_mid = '0;
      for (int r = 1; r <= 95; r++) begin
         if (r <= 91 && ld0) cnt++;
         if (r <= 91 && rdy0) nsh0++;
         if (r == 50) pts_mid = pts0;
         if (r == 91) v0 = 1'b0;
         d0 = 9'($urandom);
         step();
      end
      chk("toggle accepts", cnt, 1);
      chk("toggle ready cycles", nsh0, 0);
      chk("toggle captured data", pts_mid, 9'h155);

      // Reset for one cycle at cycle 40 of a frame
      d0 = 9'h0AA;
      v0 = 1'b1;
      d1 = 4'hA;
      v1 = 1'b1;
      step();
      v0 = 1'b0;
      v1 = 1'b0;
      cnt = 0;
      for (int r = 1; r <= 140; r++) begin
         if (r == 41) chk("abort tx_ready", rdy0, 1'b1);
         if (r >= 41 && (sh0 || dn0 || bsy0)) cnt++;
         if (r == 40) n_rst = 1'b0;
         if (r == 41) n_rst = 1'b1;
         step();
      end
      chk("abort residual activity", cnt, 0);
      d0 = 9'h133;
      v0 = 1'b1;
      step();
      v0 = 1'b0;
      done_cyc0 = -1;
      for (int r = 1; r <= 100; r++) begin
         if (dn0) done_cyc0 = r;
         step();
      end
      chk("after abort done cycle", done_cyc0, 92);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 20000; i++) begin
         v0 = ($urandom % 4 == 0);
         v1 = ($urandom % 3 == 0);
         d0 = 9'($urandom);
         d1 = 4'($urandom);
         n_rst = ($urandom % 600 != 0);
         step();
      end
      n_rst = 1'b1;
      v0 = 1'b0;
      v1 = 1'b0;
      repeat (200) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
